instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the RISC-V core, directly upstream of the control unit and decoder. Holds the program counter, issues one word request at a time to instruction memory and captures the returned instruction in an instruction register. Presents the instruction, its PC and the 7-bit opcode field to the decode/control stage with a valid/ready handshake. Accepts branch redirects from the execute stage and discards any fetch that a redirect overtakes.

## Interface
- XLEN, 32: PC and address width.
- RESET_PC, 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ImemReq  out  1  request strobe; memory accepts the request in every cycle this is high.
- ImemAddr  out  XLEN  word address of the request; equals PC.
- ImemValid  in  1  response strobe; exactly one per accepted request, at least 1 cycle after it.
- ImemData  in  32  instruction word; valid when ImemValid=1.
- BranchTaken  in  1  redirect strobe from execute.
- BranchTarget  in  XLEN  redirect address; bits [1:0] ignored and forced to 0.
- InstrValid  out  1  Instr/InstrPC/Opcode hold a live instruction.
- InstrReady  in  1  downstream accepts the instruction this cycle.
- Instr  out  32  instruction register.
- InstrPC  out  XLEN  PC of Instr.
- Opcode  out  7  Instr[6:0], fed to the control unit.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset; unconditional move to REQ next cycle.
- REQ: ImemReq=1, ImemAddr=PC, one cycle only; move to WAIT.
- WAIT: ImemReq=0. On ImemValid: if drop flag clear, Instr<=ImemData, InstrPC<=PC, InstrValid<=1, go HOLD; if drop flag set, clear it, discard data, go REQ.
- HOLD: InstrValid=1, outputs stable. On InstrValid&&InstrReady: PC<=PC+4 (wraps modulo 2^XLEN), InstrValid<=0, go REQ.
- Redirect (BranchTaken=1), highest priority over all sequential PC updates:
  - IDLE/REQ: PC<=target; REQ state continues/entered with the new PC next cycle (request issued in REQ this cycle still returns a response, so set drop flag and go WAIT).
  - WAIT: PC<=target; set drop flag (or, if ImemValid in the same cycle, discard data and go REQ directly).
  - HOLD: PC<=target, InstrValid<=0, go REQ; simultaneous InstrReady handshake still counts as consumed but the +4 increment is suppressed.
- Only one request outstanding at any time; ImemValid outside WAIT is ignored.
- Opcode is purely Instr[6:0], no extra register.

## Timing
- Reset values: PC=RESET_PC, Instr=32'h0000_0013 (NOP), InstrPC=RESET_PC, Opcode=7'b0010011, InstrValid=0, ImemReq=0, drop flag=0, state=IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately; a later stray ImemValid is ignored (state is IDLE/REQ).
- First ImemReq: 1 cycle after reset deassertion (IDLE cycle).
- 1-cycle memory: REQ at cycle n, ImemValid at n+1, InstrValid high at n+2; with InstrReady tied high, next REQ at n+3 → 3 cycles/instruction.
- InstrValid, once high, stays high with stable outputs until handshake or redirect.
- Redirect takes effect on the next edge; first request to the target at most 1 cycle after redirect (plus outstanding-response wait if in WAIT).

## Configuration
- FETCH_PERF_EN: when defined, adds output ports FetchCount (32) and StallCount (32): FetchCount increments on each accepted instruction handshake, StallCount on each HOLD cycle with InstrReady=0; both reset to 0, wrap at 2^32. When undefined, ports and counters are absent; behaviour otherwise identical.

## Structure
- Shared package riscv_pkg: opcode constants (OP_RTYPE 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011), NOP_INSTR, fetch state enum type.
- Single module; no sub-module needed (PC adder inline).

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory, InstrReady=1 -> requests at 0x100, 0x104, 0x108 on cycles 1, 4, 7; Opcode matches ImemData[6:0].
- InstrReady=0 for 5 cycles in HOLD -> InstrValid/Instr/InstrPC stable, no ImemReq; StallCount=5 with FETCH_PERF_EN.
- BranchTaken with target 0x203 during WAIT -> returned word discarded, next ImemAddr=0x200, InstrValid never high for the dropped word.
- BranchTaken simultaneous with HOLD handshake, target 0x400 -> next ImemAddr=0x400, not PC+4.
- 3-cycle memory latency -> InstrValid rises exactly 1 cycle after each ImemValid; ImemValid injected in HOLD ignored.
- Reset asserted in WAIT -> outputs immediately at reset values; PC=0xFFFF_FFFC then handshake -> next ImemAddr=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: major opcodes, the canonical NOP and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request, instruction register handed to decode via valid/ready.
// Latency: 3 cycles/instr with 1-cycle memory; redirects discard overtaken fetches.
// Backpressure: holds Instr stable while InstrReady=0. FETCH_PERF_EN adds FetchCount/StallCount.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemValid,
  input  logic [31:0]     ImemData,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchTarget,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] InstrPC,
  output logic [6:0]      Opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     FetchCount,
  output logic [31:0]     StallCount
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] instr_pc_nxt;
  logic [XLEN-1:0] target;
  logic [31:0]     instr_nxt;
  logic            valid_nxt;
  logic            drop, drop_nxt;
  logic            handshake;

  assign target    = BranchTarget & ~XLEN'(3);
  assign handshake = InstrValid && InstrReady;
  assign ImemReq   = (state == REQ);
  assign ImemAddr  = pc;
  assign Opcode    = Instr[6:0];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = Instr;
    instr_pc_nxt = InstrPC;
    valid_nxt    = InstrValid;
    drop_nxt     = drop;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        state_nxt = WAIT;
        // the request just issued will still answer; mark it stale
        if (BranchTaken) drop_nxt = 1'b1;
      end
      WAIT: begin
        if (ImemValid) begin
          if (drop || BranchTaken) begin
            drop_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            instr_nxt    = ImemData;
            instr_pc_nxt = pc;
            valid_nxt    = 1'b1;
            state_nxt    = HOLD;
          end
        end else if (BranchTaken) begin
          drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end else if (handshake) begin
          pc_nxt    = pc + XLEN'(4);
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // redirect overrides any sequential PC update
    if (BranchTaken) pc_nxt = target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      Instr      <= NOP_INSTR;
      InstrPC    <= RESET_PC;
      InstrValid <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      Instr      <= instr_nxt;
      InstrPC    <= instr_pc_nxt;
      InstrValid <= valid_nxt;
      drop       <= drop_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (handshake) FetchCount <= FetchCount + 32'd1;
      if (state == HOLD && !InstrReady) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand sequences for latency, drop, wrap and reset.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [6:0]  Opcode;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemValid(ImemValid), .ImemData(ImemData),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrPC(InstrPC), .Opcode(Opcode)
`ifdef FETCH_PERF_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // memory image: word index in the upper bits, opcode cycling through the major classes
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = OP_RTYPE;
      2'd1:    op = OP_LOAD;
      2'd2:    op = OP_STORE;
      default: op = OP_BRANCH;
    endcase
    return {a[26:2], op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory responder: answers each request lat cycles later; inject forces a stray response
  int          lat    = 1;
  logic        inject = 1'b0;
  int          cnt    = 0;
  logic [31:0] raddr  = '0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      cnt       = 0;
      ImemValid = 1'b0;
    end else begin
      ImemValid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ImemValid = 1'b1;
          ImemData  = mem(raddr);
        end
      end
      if (inject) begin
        ImemValid = 1'b1;
        ImemData  = 32'hDEAD_BEEF;
      end
      if (ImemReq) begin
        cnt   = lat;
        raddr = ImemAddr;
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t,
                              input logic rq, input logic [31:0] ad,
                              input logic v, input logic [31:0] p);
    vec_t x;
    x.ready = r; x.br = b; x.tgt = t;
    x.exp_req = rq; x.exp_addr = ad; x.exp_valid = v; x.exp_pc = p;
    return x;
  endfunction

  task automatic check_hold(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"},  {31'd0, InstrValid}, 32'd1);
    chk({tag, ".pc"},     InstrPC, pc);
    chk({tag, ".instr"},  Instr, mem(pc));
    chk({tag, ".opcode"}, {25'd0, Opcode}, {25'd0, mem(pc) & 32'h7F});
    chk({tag, ".req"},    {31'd0, ImemReq}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".valid"},  {31'd0, InstrValid}, 32'd0);
    chk({tag, ".req"},    {31'd0, ImemReq}, 32'd0);
    chk({tag, ".instr"},  Instr, NOP_INSTR);
    chk({tag, ".pc"},     InstrPC, 32'h100);
    chk({tag, ".opcode"}, {25'd0, Opcode}, 32'h13);
    chk({tag, ".addr"},   ImemAddr, 32'h100);
  endtask

  initial begin
    reset = 1'b1; ImemValid = 1'b0; ImemData = '0;
    BranchTaken = 1'b0; BranchTarget = '0; InstrReady = 1'b1;

    // cycle-by-cycle script starting in IDLE right after reset release
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 0 IDLE
    tbl.push_back(mk(1,0,0,         1,32'h100,  0,0));         // 1 REQ
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 2 WAIT
    tbl.push_back(mk(1,0,0,         0,0,        1,32'h100));   // 3 HOLD
    tbl.push_back(mk(1,0,0,         1,32'h104,  0,0));         // 4
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 5
    tbl.push_back(mk(1,0,0,         0,0,        1,32'h104));   // 6
    tbl.push_back(mk(1,0,0,         1,32'h108,  0,0));         // 7
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 8
    for (int i = 9; i <= 13; i++)
      tbl.push_back(mk(0,0,0,       0,0,        1,32'h108));   // 9..13 stalled
    tbl.push_back(mk(1,0,0,         0,0,        1,32'h108));   // 14 handshake
    tbl.push_back(mk(1,0,0,         1,32'h10C,  0,0));         // 15
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 16
    tbl.push_back(mk(1,0,0,         0,0,        1,32'h10C));   // 17
    tbl.push_back(mk(1,0,0,         1,32'h110,  0,0));         // 18
    tbl.push_back(mk(1,1,32'h203,   0,0,        0,0));         // 19 WAIT+redirect+response
    tbl.push_back(mk(1,0,0,         1,32'h200,  0,0));         // 20
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 21
    tbl.push_back(mk(1,1,32'h400,   0,0,        1,32'h200));   // 22 HOLD handshake+redirect
    tbl.push_back(mk(1,0,0,         1,32'h400,  0,0));         // 23
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 24
    tbl.push_back(mk(1,0,0,         0,0,        1,32'h400));   // 25
    tbl.push_back(mk(1,1,32'h500,   1,32'h404,  0,0));         // 26 REQ+redirect
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 27 stale response dropped
    tbl.push_back(mk(1,0,0,         1,32'h500,  0,0));         // 28
    tbl.push_back(mk(1,0,0,         0,0,        0,0));         // 29
    tbl.push_back(mk(0,0,0,         0,0,        1,32'h500));   // 30

    tick(); tick();
    check_reset_vals("rst");
    reset = 1'b0;

    foreach (tbl[i]) begin
      InstrReady   = tbl[i].ready;
      BranchTaken  = tbl[i].br;
      BranchTarget = tbl[i].tgt;
      chk($sformatf("v%0d.req", i), {31'd0, ImemReq}, {31'd0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("v%0d.addr", i), ImemAddr, tbl[i].exp_addr);
      chk($sformatf("v%0d.valid", i), {31'd0, InstrValid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("v%0d.pc", i), InstrPC, tbl[i].exp_pc);
        chk($sformatf("v%0d.instr", i), Instr, mem(tbl[i].exp_pc));
        chk($sformatf("v%0d.opcode", i), {25'd0, Opcode}, {25'd0, mem(tbl[i].exp_pc) & 32'h7F});
      end
      tick();
    end
    BranchTaken = 1'b0;
`ifdef FETCH_PERF_EN
    chk("perf.fetch", FetchCount, 32'd6);
    chk("perf.stall", StallCount, 32'd6);
`endif

    // stray response during HOLD must not disturb the held instruction
    InstrReady = 1'b0; inject = 1'b1; lat = 3;
    tick();
    inject = 1'b0;
    check_hold("stray", 32'h500);
    InstrReady = 1'b1;
    tick();
    chk("lat3.req", {31'd0, ImemReq}, 32'd1);
    chk("lat3.addr", ImemAddr, 32'h504);
    tick();
    // redirect in WAIT before the response: response must be dropped later
    BranchTaken = 1'b1; BranchTarget = 32'h600;
    tick();
    BranchTaken = 1'b0;
    chk("drop.w2.valid", {31'd0, InstrValid}, 32'd0);
    tick();
    chk("drop.w3.valid", {31'd0, InstrValid}, 32'd0);
    tick();
    chk("drop.req", {31'd0, ImemReq}, 32'd1);
    chk("drop.addr", ImemAddr, 32'h600);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("lat3.wait%0d.valid", k), {31'd0, InstrValid}, 32'd0);
    end
    tick();
    check_hold("lat3.hold", 32'h600);

    // PC wrap: redirect to the last word (low bits forced to 0), then handshake
    lat = 1; BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFF;
    tick();
    BranchTaken = 1'b0;
    chk("wrap.req", {31'd0, ImemReq}, 32'd1);
    chk("wrap.addr", ImemAddr, 32'hFFFF_FFFC);
    tick(); tick();
    check_hold("wrap.hold", 32'hFFFF_FFFC);
    tick();
    chk("wrap.next", ImemAddr, 32'h0000_0000);
    chk("wrap.nreq", {31'd0, ImemReq}, 32'd1);

    // reset asserted while waiting on a response
    lat = 3;
    tick();
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    reset = 1'b0;
    inject = 1'b1;
    tick();
    inject = 1'b0;
`ifdef FETCH_PERF_EN
    chk("midrst.fetch", FetchCount, 32'd0);
    chk("midrst.stall", StallCount, 32'd0);
`endif
    chk("post.req", {31'd0, ImemReq}, 32'd1);
    chk("post.addr", ImemAddr, 32'h100);
    chk("post.valid", {31'd0, InstrValid}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("post.wait%0d.valid", k), {31'd0, InstrValid}, 32'd0);
    end
    tick();
    check_hold("post.hold", 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
